// File: rtl/vend_pkg.sv
// Shared constants and BCD arithmetic helpers for the vending front end.
// Key indices, default parameters, and 6-digit packed-BCD add/subtract.
// Pure package with no ports; imported by key_debounce and coin_key_accum.
package vend_pkg;

   localparam int K_COIN0  = 0;
   localparam int K_COIN1  = 1;
   localparam int K_REFUND = 2;
   localparam int K_BUY    = 3;

   localparam int BCD_W   = 4;
   localparam int NUM_DIG = 6;
   localparam int CRED_W  = BCD_W * NUM_DIG;

   localparam int                DB_CNT_DEF = 1000000;
   localparam logic [CRED_W-1:0] PRICE_DEF  = 24'h000300;
   localparam logic [CRED_W-1:0] COIN0_DEF  = 24'h000050;
   localparam logic [CRED_W-1:0] COIN1_DEF  = 24'h000100;

   // Digit-wise BCD add. Bit CRED_W is the carry out of the top digit.
   function automatic logic [CRED_W:0] bcd_add(input logic [CRED_W-1:0] a,
                                               input logic [CRED_W-1:0] b);
      logic [CRED_W-1:0] s;
      logic              c;
      logic [BCD_W:0]    t;
      s = '0;
      c = 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
         t = {1'b0, a[i*BCD_W +: BCD_W]} + {1'b0, b[i*BCD_W +: BCD_W]} + {4'b0, c};
         // Digit sums above 9 skip the six unused codes and carry.
         if (t > 5'd9) begin
            t = t + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[i*BCD_W +: BCD_W] = t[BCD_W-1:0];
      end
      return {c, s};
   endfunction

   // Digit-wise BCD subtract; caller guarantees a >= b.
   function automatic logic [CRED_W-1:0] bcd_sub(input logic [CRED_W-1:0] a,
                                                 input logic [CRED_W-1:0] b);
      logic [CRED_W-1:0] s;
      logic              br;
      logic [BCD_W:0]    t;
      s  = '0;
      br = 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
         t = {1'b0, a[i*BCD_W +: BCD_W]} - {1'b0, b[i*BCD_W +: BCD_W]} - {4'b0, br};
         // A negative digit difference borrows ten from the next digit.
         if (t[BCD_W]) begin
            t  = t + 5'd10;
            br = 1'b1;
         end else begin
            br = 1'b0;
         end
         s[i*BCD_W +: BCD_W] = t[BCD_W-1:0];
      end
      return s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one active-low push-button and emits a one-cycle press pulse.
// Latency: 2-flop synchronizer + DB_CNT stable samples; pulse in the cycle the level falls.
// Ports: sclk, rst (sync active-high), key_n (raw, async), press (one-cycle pulse). No backpressure.
module key_debounce
   import vend_pkg::*;
#(
   parameter int DB_CNT = DB_CNT_DEF
) (
   input  logic sclk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int            CW      = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d  = key_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      // Count consecutive disagreeing samples; any agreeing sample restarts the count.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = stable_q & ~stable_d;
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/coin_key_accum.sv
// Vending front end: debounced key presses drive a 6-digit BCD credit with coin/refund/purchase.
// Latency: credit and vend update one cycle after the flag_key pulse.
// Ports: sclk, rst, key_in[3:0] (active-low raw), flag_key[3:0], rNum[23:0] (BCD), vend. No backpressure.
module coin_key_accum
   import vend_pkg::*;
#(
   parameter int                DB_CNT = DB_CNT_DEF,
   parameter logic [CRED_W-1:0] PRICE  = PRICE_DEF,
   parameter logic [CRED_W-1:0] COIN0  = COIN0_DEF,
   parameter logic [CRED_W-1:0] COIN1  = COIN1_DEF
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic [3:0]        key_in,
   output logic [3:0]        flag_key,
   output logic [CRED_W-1:0] rNum,
   output logic              vend
);

   logic [3:0]        press;
   logic [CRED_W-1:0] rnum_q, rnum_d;
   logic              vend_q, vend_d;
   logic [CRED_W:0]   add0, add1;
   logic [CRED_W-1:0] sub_v;

   for (genvar g = 0; g < 4; g++) begin : g_db
      key_debounce #(.DB_CNT(DB_CNT)) u_db (
         .sclk  (sclk),
         .rst   (rst),
         .key_n (key_in[g]),
         .press (press[g])
      );
   end

   always_comb begin
      rnum_d = rnum_q;
      vend_d = 1'b0;
      add0   = bcd_add(rnum_q, COIN0);
      add1   = bcd_add(rnum_q, COIN1);
      sub_v  = bcd_sub(rnum_q, PRICE);
      // Single action per cycle; lower-priority presses in the same cycle are ignored.
      // Valid BCD compares correctly as plain unsigned binary.
      if (press[K_REFUND]) begin
         rnum_d = '0;
      end else if (press[K_BUY]) begin
         if (rnum_q >= PRICE) begin
            rnum_d = sub_v;
            vend_d = 1'b1;
         end
      end else if (press[K_COIN1]) begin
         if (!add1[CRED_W]) rnum_d = add1[CRED_W-1:0];
      end else if (press[K_COIN0]) begin
         if (!add0[CRED_W]) rnum_d = add0[CRED_W-1:0];
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         rnum_q <= '0;
         vend_q <= 1'b0;
      end else begin
         rnum_q <= rnum_d;
         vend_q <= vend_d;
      end
   end

   assign flag_key = press;
   assign rNum     = rnum_q;
   assign vend     = vend_q;

endmodule

// File: tb/tb_coin_key_accum.sv
// Self-checking bench for coin_key_accum with a behavioural credit/debounce model.
// Directed scenarios with literal expectations, then a randomized phase.
// Model compared against the DUT every cycle, 3 ns after the rising edge.
module tb_coin_key_accum;

   localparam int DB = 8;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_in = 4'hF;
   logic [3:0]  flag_key;
   logic [23:0] rnum;
   logic        vend;

   int   n_checks = 0;
   int   n_pass = 0;
   bit   on = 1'b0;
   int   flag_cnt [4] = '{0, 0, 0, 0};
   int   vend_cnt = 0;
   logic [3:0] last_flag = 4'h0;
   bit   preload_req = 1'b0;
   int   preload_val = 0;

   // Behavioural model state
   logic [3:0] hist[$];
   logic [3:0] stable_m;
   logic [3:0] exp_flag;
   logic       exp_vend;
   int         credit;

   coin_key_accum #(.DB_CNT(DB)) dut (
      .sclk     (sclk),
      .rst      (rst),
      .key_in   (key_in),
      .flag_key (flag_key),
      .rNum     (rnum),
      .vend     (vend)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int x;
      x = v;
      r = '0;
      for (int d = 0; d < 6; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Model: a key's level changes once its input, seen two samples late, has
   // disagreed with the level for DB samples in a row. Credit is plain integer fen.
   always @(posedge sclk) begin
      logic [3:0] nf;
      bit all_diff;
      if (rst) begin
         credit   = 0;
         exp_flag = 4'h0;
         exp_vend = 1'b0;
         stable_m = 4'hF;
         hist.delete();
         for (int j = 0; j < DB + 2; j++) hist.push_back(4'hF);
      end else begin
         exp_vend = 1'b0;
         if (exp_flag[2]) credit = 0;
         else if (exp_flag[3]) begin
            if (credit >= 300) begin
               credit   = credit - 300;
               exp_vend = 1'b1;
            end
         end else if (exp_flag[1]) begin
            if (credit + 100 <= 999999) credit = credit + 100;
         end else if (exp_flag[0]) begin
            if (credit + 50 <= 999999) credit = credit + 50;
         end
         if (preload_req) credit = preload_val;
         hist.push_front(key_in);
         void'(hist.pop_back());
         nf = 4'h0;
         for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 2; j < DB + 2; j++)
               if (hist[j][i] == stable_m[i]) all_diff = 1'b0;
            if (all_diff) begin
               stable_m[i] = ~stable_m[i];
               if (!stable_m[i]) nf[i] = 1'b1;
            end
         end
         exp_flag = nf;
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(posedge sclk);
         #3;
         if (on) begin
            chk("flag_key", 32'(flag_key), 32'(exp_flag));
            chk("rNum", 32'(rnum), 32'(to_bcd(credit)));
            chk("vend", 32'(vend), 32'(exp_vend));
            for (int i = 0; i < 4; i++) flag_cnt[i] += int'(flag_key[i]);
            if (flag_key != 4'h0) last_flag = flag_key;
            vend_cnt += int'(vend);
         end
      end
   end

   task automatic press(input logic [3:0] m, input int hold, input int gap);
      @(negedge sclk);
      key_in = 4'hF & ~m;
      repeat (hold) @(negedge sclk);
      key_in = 4'hF;
      repeat (gap) @(negedge sclk);
   endtask

   task automatic press_n(input logic [3:0] m, input int n);
      for (int k = 0; k < n; k++) press(m, 20, 14);
   endtask

   initial begin
      int f0, f1, f3, v0, first;
      repeat (3) @(negedge sclk);
      on = 1'b1;
      chk("reset_rnum", 32'(rnum), 32'h0);
      chk("reset_flag", 32'(flag_key), 32'h0);
      chk("reset_vend", 32'(vend), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge sclk);

      // Single coin 0.50, one flag only
      f0 = flag_cnt[0];
      press(4'b0001, 20, 14);
      chk("coin0_rnum", 32'(rnum), 32'h000050);
      chk("coin0_one_flag", 32'(flag_cnt[0] - f0), 32'd1);

      // 5-cycle glitch on key1 is ignored
      f1 = flag_cnt[1];
      press(4'b0010, 5, 20);
      chk("glitch_rnum", 32'(rnum), 32'h000050);
      chk("glitch_no_flag", 32'(flag_cnt[1] - f1), 32'd0);
      press(4'b0010, 20, 14);
      chk("coin1_rnum", 32'(rnum), 32'h000150);
      press(4'b0010, 20, 14);

      // Purchase with too little credit
      f3 = flag_cnt[3];
      v0 = vend_cnt;
      press(4'b1000, 20, 14);
      chk("buy_short_flag", 32'(flag_cnt[3] - f3), 32'd1);
      chk("buy_short_vend", 32'(vend_cnt - v0), 32'd0);
      chk("buy_short_rnum", 32'(rnum), 32'h000250);

      // Exact price, then from 3.50
      press(4'b0001, 20, 14);
      v0 = vend_cnt;
      press(4'b1000, 20, 14);
      chk("buy_exact_vend", 32'(vend_cnt - v0), 32'd1);
      chk("buy_exact_rnum", 32'(rnum), 32'h000000);
      press_n(4'b0010, 3);
      press(4'b0001, 20, 14);
      press(4'b1000, 20, 14);
      chk("buy_350_rnum", 32'(rnum), 32'h000050);

      // BCD carry across several digits
      press_n(4'b0010, 9);
      chk("pre_carry_rnum", 32'(rnum), 32'h000950);
      press(4'b0001, 20, 14);
      chk("carry_rnum", 32'(rnum), 32'h001000);

      // Saturation near the top of the range
      @(negedge sclk);
      force dut.rnum_q = 24'h999950;
      preload_val = 999950;
      preload_req = 1'b1;
      @(negedge sclk);
      preload_req = 1'b0;
      release dut.rnum_q;
      press(4'b0010, 20, 14);
      chk("sat_coin1_rnum", 32'(rnum), 32'h999950);
      press(4'b0001, 20, 14);
      chk("sat_coin0_rnum", 32'(rnum), 32'h999950);

      // All four keys together: refund wins
      press(4'b0100, 20, 14);
      chk("refund_rnum", 32'(rnum), 32'h000000);
      press_n(4'b0010, 5);
      v0 = vend_cnt;
      last_flag = 4'h0;
      press(4'b1111, 20, 14);
      chk("all4_flags", 32'(last_flag), 32'hF);
      chk("all4_rnum", 32'(rnum), 32'h000000);
      chk("all4_vend", 32'(vend_cnt - v0), 32'd0);

      // Buy beats coin1 when pressed together
      press_n(4'b0010, 3);
      v0 = vend_cnt;
      press(4'b1010, 20, 14);
      chk("buy_coin1_vend", 32'(vend_cnt - v0), 32'd1);
      chk("buy_coin1_rnum", 32'(rnum), 32'h000000);

      // Reset while key0 is mid-debounce
      press(4'b0010, 20, 14);
      @(negedge sclk);
      key_in = 4'b1110;
      repeat (4) @(negedge sclk);
      rst = 1'b1;
      @(negedge sclk);
      chk("midrst_rnum", 32'(rnum), 32'h0);
      chk("midrst_flag", 32'(flag_key), 32'h0);
      @(negedge sclk);
      rst = 1'b0;
      first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge sclk);
         if (flag_key[0] && first == 0) first = k;
      end
      n_checks++;
      if (first >= DB + 2 && first <= DB + 3) n_pass++;
      else $display("FAIL midrst_latency actual=%0d required=%0d..%0d", first, DB + 2, DB + 3);
      key_in = 4'hF;
      repeat (14) @(negedge sclk);

      // Randomized phase
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 19) == 0) begin
            @(negedge sclk);
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge sclk);
            rst = 1'b0;
         end
         press(4'($urandom_range(1, 15)), int'($urandom_range(1, 22)), int'($urandom_range(0, 14)));
      end
      key_in = 4'hF;
      repeat (15) @(negedge sclk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/coin_key_accum.md
Name: coin_key_accum

Overview:
- Front end of the vending machine. Takes the four raw push-buttons, debounces them, and issues one-cycle press flags on flag_key.
- Maintains the customer's credit as a 6-digit BCD amount on rNum.
- flag_key and rNum feed led_ctrl and the display.
- Also executes purchases at a fixed price and issues refunds.

Parameters:
- DB_CNT, 1000000: stable-sample cycles required to accept a key level change (20 ms at 50 MHz).
- PRICE, 24'h000300: item price, BCD fen (3.00 yuan).
- COIN0, 24'h000050: credit added by key 0, BCD fen (0.50 yuan).
- COIN1, 24'h000100: credit added by key 1, BCD fen (1.00 yuan).

Ports:
- sclk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- key_in  in  4  raw buttons, active-low, asynchronous to sclk. Key 0 = coin 0.5, key 1 = coin 1, key 2 = refund, key 3 = purchase.
- flag_key  out  4  one-cycle press pulse per key, after debounce.
- rNum  out  24  credit, BCD digits d5..d0 (d5d4d3d2.d1d0 yuan). [15:12] is the tens-of-yuan digit; [11:8] is the yuan digit.
- vend  out  1  one-cycle pulse when a purchase succeeds.

Behaviour:
- Reset, sampled on the sclk edge while rst=1:
  - flag_key=0, rNum=0, vend=0.
  - All synchronizers = 1111 (released), debounced levels = 1, debounce counters = 0.
- Synchronizer:
  - key_in passes through 2 flip-flops per bit before the debounce logic.
- Debounce, per key:
  - The counter increments while the synchronized sample differs from the stable level.
  - The counter clears whenever the sample equals the stable level.
  - When the counter reaches DB_CNT-1, the stable level takes the sample value and the counter clears.
  - A glitch shorter than DB_CNT cycles never changes the stable level.
- Press flag:
  - flag_key[i]=1 for exactly one cycle, in the cycle after stable[i] falls from 1 to 0.
  - Release (stable rising) produces no flag.
  - A held key produces one flag only.
- Credit update:
  - rNum and vend register in the cycle after the flag cycle (flag at cycle N, rNum/vend at N+1).
  - One action per cycle, by priority: key2 refund > key3 purchase > key1 > key0.
  - Lower-priority flags in the same cycle are dropped for the credit update, but their flag_key pulses still appear.
- Refund: rNum <= 0. vend stays 0.
- Purchase:
  - If rNum >= PRICE (BCD magnitude compare): rNum <= rNum - PRICE (digit-wise BCD subtract with borrow), and vend=1 for one cycle.
  - Otherwise rNum is unchanged and vend=0. flag_key[3] still pulses so led_ctrl can blink.
- Coin:
  - rNum <= rNum + COINx, using digit-wise BCD add. A digit sum greater than 9 adds 6 and carries to the next digit.
  - Saturation: if the add would carry out of d5 (result above 9999.99), rNum is unchanged.
- Invariant: every rNum digit is always 0-9.
- Reset mid-operation:
  - A pending debounce count and any in-flight action are discarded.
  - A key held through reset yields one flag DB_CNT+2 to DB_CNT+3 cycles after rst deasserts.

Decomposition:
- Shared package vend_pkg:
  - Key index constants: K_COIN0=0, K_COIN1=1, K_REFUND=2, K_BUY=3.
  - Default PRICE, COIN0, COIN1, DB_CNT.
  - BCD digit width constant (4).
- Sub-module key_debounce, instantiated 4 times:
  - Inputs: sclk, rst, key_n.
  - Output: press pulse.
  - Contains the synchronizer, counter, stable level, and falling-edge detect.
- Top level holds the priority mux, the BCD adder/subtractor/comparator, and the output registers.

Test Plan (DB_CNT=8 in the bench):
- Reset, then key0 low for 20 cycles → exactly one flag_key[0] pulse. One cycle later rNum=24'h000050. No further flag on release.
- 5-cycle low glitch on key1 → no flag_key, rNum unchanged. Then a valid press → rNum +100.
- Credit 2.50, press key3 → flag_key[3] pulse, vend=0, rNum stays 000250.
- Continue from the previous scenario: press key0 to reach 3.00, press key3 → vend pulse, rNum=000000. Separately from 3.50 → rNum=000050.
- BCD carry and saturation:
  - Start at 000950, press key0 → rNum=001000.
  - Preload to 999950 via repeated presses (or force), press key1 → rNum stays 999950.
  - From 999950, press key0 → rNum=999999 is not reachable, because COIN0 added to x950 gives 1000000, which overflows and saturates: rNum stays 999950.
- Simultaneous presses (drive all four keys together):
  - From 005.00, press all four keys together → all four flag_key bits pulse in one cycle, rNum=0 (refund wins), vend=0.
  - Repeat with only key3 and key1 pressed together from 3.00 → vend=1, rNum=0.
- Assert rst while a key is held mid-debounce → rNum=0 and flag_key=0 immediately. One flag arrives DB_CNT+2 to DB_CNT+3 cycles after release of rst.
